score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_pkg.sv | 22 ++
 rtl/score_keeper_sync_edge.sv | 29 ++
 rtl/score_keeper.sv | 107 ++++++++++
 tb/tb_score_keeper.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared game definitions: FSM encodings, game-status codes and counter limits
// used by the score keeper and the game-status block.
package score_keeper_pkg;

    localparam int unsigned CNT_W           = 5;
    localparam int unsigned CNT_MAX_DEFAULT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } sk_state_e;

    typedef enum logic [1:0] {
        GS_RESET   = 2'b00,
        GS_PLAYING = 2'b01,
        GS_WON     = 2'b10,
        GS_OVER    = 2'b11
    } game_state_e;

endpackage

// File: rtl/score_keeper_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse_o is one
// clk cycle wide and is valid two edges after the input level rises.
module sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Decoded straight from flops so the FSM sees the event on the third edge.
    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Score keeper: counts accepted hits and misses with a post-event lockout
// measured in 1 ms ticks, and freezes once the game is won or over.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned HOLDOFF_MS = 20,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       hit,
    input  logic       miss,
    input  logic       start,
    input  logic [1:0] game_state,
    output logic [4:0] player_score,
    output logic [4:0] gameOver,
    output logic       busy
);

    localparam int unsigned LOCK_W = (HOLDOFF_MS == 0) ? 1 : $clog2(HOLDOFF_MS + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(HOLDOFF_MS);
    localparam logic [CNT_W-1:0]  SAT_VAL   = CNT_W'(CNT_MAX);

    sk_state_e         state_q, state_d;
    logic [CNT_W-1:0]  score_q, score_d;
    logic [CNT_W-1:0]  over_q,  over_d;
    logic [LOCK_W-1:0] lock_q,  lock_d;
    logic              busy_q,  busy_d;

    logic hit_p, miss_p, start_p, tick_p;
    logic finished;

    sync_edge u_sync_hit   (.clk_i(clk), .rst_n_i(reset), .d_i(hit),     .pulse_o(hit_p));
    sync_edge u_sync_miss  (.clk_i(clk), .rst_n_i(reset), .d_i(miss),    .pulse_o(miss_p));
    sync_edge u_sync_start (.clk_i(clk), .rst_n_i(reset), .d_i(start),   .pulse_o(start_p));
    sync_edge u_sync_tick  (.clk_i(clk), .rst_n_i(reset), .d_i(clk_1ms), .pulse_o(tick_p));

    assign finished = (game_state == GS_WON) || (game_state == GS_OVER);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= SAT_VAL) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            over_q  <= '0;
            lock_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            over_q  <= over_d;
            lock_q  <= lock_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        over_d  = over_q;
        lock_d  = lock_q;

        case (state_q)
            ST_IDLE: begin
                score_d = '0;
                over_d  = '0;
                if (start_p) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Game end outranks a same-cycle hit or miss.
                if (finished) begin
                    state_d = ST_DONE;
                end else if (hit_p || miss_p) begin
                    if (hit_p) score_d = sat_inc(score_q);
                    else       over_d  = sat_inc(over_q);
                    lock_d  = LOCK_LOAD;
                    state_d = (HOLDOFF_MS == 0) ? ST_PLAY : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick_p || (lock_q == '0)) begin
                    lock_d = (lock_q == '0) ? '0 : lock_q - LOCK_W'(1);
                    if (lock_d == '0) state_d = finished ? ST_DONE : ST_PLAY;
                end
            end
            ST_DONE: begin
                if (start_p) begin
                    score_d = '0;
                    over_d  = '0;
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_HOLD);
    end

    assign player_score = score_q;
    assign gameOver     = over_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with hand-computed expectations.
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_1ms;
    logic       hit;
    logic       miss;
    logic       start;
    logic [1:0] game_state;
    logic [4:0] player_score;
    logic [4:0] gameOver;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    score_keeper #(.HOLDOFF_MS(20), .CNT_MAX(31)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_1ms     (clk_1ms),
        .hit         (hit),
        .miss        (miss),
        .start       (start),
        .game_state  (game_state),
        .player_score(player_score),
        .gameOver    (gameOver),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 1 ms tick: level high for 3 clks, low for 3 clks.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_1ms = 1'b1;
            cyc(3);
            clk_1ms = 1'b0;
            cyc(3);
        end
    endtask

    function automatic logic [31:0] st(input sk_state_e s);
        return 32'(s);
    endfunction

    initial begin
        reset = 1'b0; clk_1ms = 1'b0; hit = 1'b0; miss = 1'b0; start = 1'b0;
        game_state = 2'b01;
        @(posedge clk); #1;
        cyc(2);
        chk("rst_score", 32'(player_score), 0);
        chk("rst_over",  32'(gameOver), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_state", 32'(dut.state_q), st(ST_IDLE));

        // Start: PLAY exactly three edges after start rises.
        reset = 1'b1; start = 1'b1;
        cyc(2);
        chk("start_lat2", 32'(dut.state_q), st(ST_IDLE));
        cyc(1);
        chk("start_lat3", 32'(dut.state_q), st(ST_PLAY));
        chk("start_score", 32'(player_score), 0);
        chk("start_over",  32'(gameOver), 0);
        start = 1'b0;
        cyc(2);

        // First hit accepted, then five extra hits in HOLD are ignored.
        hit = 1'b1;
        cyc(2);
        chk("hit_lat2", 32'(player_score), 0);
        cyc(1);
        chk("hit_lat3", 32'(player_score), 1);
        chk("hit_busy", 32'(busy), 1);
        hit = 1'b0;
        cyc(2);
        for (int i = 0; i < 5; i++) begin
            hit = 1'b1;
            ticks(1);
            hit = 1'b0;
            ticks(1);
        end
        chk("hold_ign_score", 32'(player_score), 1);
        ticks(9);
        chk("hold_busy_19", 32'(busy), 1);
        ticks(1);
        chk("hold_busy_20", 32'(busy), 0);
        chk("hold_exit_st", 32'(dut.state_q), st(ST_PLAY));

        // Simultaneous hit and miss: hit wins.
        hit = 1'b1; miss = 1'b1;
        cyc(3);
        chk("sim_score", 32'(player_score), 2);
        chk("sim_over",  32'(gameOver), 0);
        hit = 1'b0; miss = 1'b0;
        cyc(1);
        ticks(20);

        // Miss counter saturates at 31.
        for (int i = 1; i <= 32; i++) begin
            miss = 1'b1;
            cyc(3);
            chk("miss_sat", 32'(gameOver), (i > 31) ? 32'd31 : 32'(i));
            miss = 1'b0;
            cyc(1);
            ticks(20);
        end
        chk("miss_keep_score", 32'(player_score), 2);

        // Game won while in HOLD: DONE after lockout, hits ignored, start restarts.
        hit = 1'b1;
        cyc(3);
        chk("won_hit", 32'(player_score), 3);
        hit = 1'b0;
        cyc(1);
        game_state = 2'b10;
        ticks(5);
        hit = 1'b1;
        ticks(2);
        hit = 1'b0;
        ticks(12);
        chk("won_busy19", 32'(busy), 1);
        ticks(1);
        chk("won_state", 32'(dut.state_q), st(ST_DONE));
        chk("won_busy",  32'(busy), 0);
        hit = 1'b1;
        cyc(4);
        hit = 1'b0;
        cyc(1);
        chk("done_freeze", 32'(player_score), 3);
        game_state = 2'b01; start = 1'b1;
        cyc(3);
        chk("restart_score", 32'(player_score), 0);
        chk("restart_over",  32'(gameOver), 0);
        chk("restart_state", 32'(dut.state_q), st(ST_PLAY));
        start = 1'b0;
        cyc(2);

        // Game over arriving on the same edge as a hit pulse takes priority.
        hit = 1'b1;
        cyc(2);
        game_state = 2'b11;
        cyc(1);
        chk("prio_state", 32'(dut.state_q), st(ST_DONE));
        chk("prio_score", 32'(player_score), 0);
        hit = 1'b0; game_state = 2'b01; start = 1'b1;
        cyc(3);
        chk("prio_restart", 32'(dut.state_q), st(ST_PLAY));
        start = 1'b0;
        cyc(2);

        // Reset mid-HOLD with score 7 aborts everything.
        for (int k = 1; k <= 7; k++) begin
            hit = 1'b1;
            cyc(3);
            hit = 1'b0;
            cyc(1);
            if (k < 7) ticks(20);
        end
        ticks(3);
        chk("pre_rst_score", 32'(player_score), 7);
        chk("pre_rst_busy",  32'(busy), 1);
        reset = 1'b0;
        cyc(1);
        chk("mid_rst_score", 32'(player_score), 0);
        chk("mid_rst_busy",  32'(busy), 0);
        chk("mid_rst_state", 32'(dut.state_q), st(ST_IDLE));
        reset = 1'b1;
        cyc(2);
        hit = 1'b1;
        cyc(4);
        hit = 1'b0;
        cyc(1);
        chk("idle_hit_ign", 32'(player_score), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
